// File: rtl/shift_arb_ctrl.sv
// Two-requester arbiter and sequencer for the shared 32-bit left-only shifter.
// Right shifts use operand bit reversal; SRA of a negative operand adds a second mask pass for the sign fill.
module shift_arb_ctrl #(
  parameter int RR_EN   = 1,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [1:0]         req_op0,
  input  logic [1:0]         req_op1,
  input  logic [SHAMT_W-1:0] req_shamt0,
  input  logic [SHAMT_W-1:0] req_shamt1,
  input  logic [31:0]        req_data0,
  input  logic [31:0]        req_data1,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_data,
  output logic               rsp_src,
  output logic [31:0]        sh_onehot,
  output logic               sh_right,
  output logic [31:0]        sh_datain,
  input  logic [31:0]        sh_dataout
);

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, RESP} state_t;

  state_t              state;
  logic                ptr;
  logic                op_right;
  logic                sra_neg;
  logic                cur_src;
  logic [31:0]         tmp;
  logic [1:0]          grant;
  logic                sel_src;
  logic [1:0]          sel_op;
  logic [SHAMT_W-1:0]  sel_shamt;
  logic [31:0]         sel_data;
  logic [31:0]         pass1_res;

  function automatic logic [31:0] bitrev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Grant is only offered while idle and out of reset; the pointer breaks ties.
  always_comb begin
    grant = 2'b00;
    if (state == IDLE && rst_n) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;
  assign sh_right  = 1'b0;
  assign sel_src   = grant[1];
  assign sel_op    = sel_src ? req_op1    : req_op0;
  assign sel_shamt = sel_src ? req_shamt1 : req_shamt0;
  assign sel_data  = sel_src ? req_data1  : req_data0;
  assign pass1_res = op_right ? bitrev(sh_dataout) : sh_dataout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      op_right  <= 1'b0;
      sra_neg   <= 1'b0;
      cur_src   <= 1'b0;
      tmp       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_src   <= 1'b0;
      sh_onehot <= '0;
      sh_datain <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            op_right  <= sel_op[0];
            sra_neg   <= (sel_op == 2'b11) && sel_data[31];
            cur_src   <= sel_src;
            sh_onehot <= 32'd1 << sel_shamt;
            sh_datain <= sel_op[0] ? bitrev(sel_data) : sel_data;
            if (RR_EN != 0) ptr <= ~sel_src;
            state     <= PASS1;
          end
        end
        PASS1: begin
          tmp <= pass1_res;
          if (sra_neg) begin
            sh_datain <= 32'hFFFF_FFFF;
            state     <= PASS2;
          end else begin
            sh_onehot <= '0;
            sh_datain <= '0;
            rsp_data  <= pass1_res;
            rsp_src   <= cur_src;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        // All-ones shifted left leaves zeros in the low shamt bits; reversed and inverted that is the sign fill.
        PASS2: begin
          sh_onehot <= '0;
          sh_datain <= '0;
          rsp_data  <= tmp | ~bitrev(sh_dataout);
          rsp_src   <= cur_src;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_arb_ctrl.sv
// Directed bench for shift_arb_ctrl: a round-robin and a fixed-priority instance share stimulus,
// each driven by its own behavioural one-hot left shifter.
module tb_shift_arb_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_op0, req_op1;
  logic [4:0]  req_shamt0, req_shamt1;
  logic [31:0] req_data0, req_data1;
  logic        rsp_ready;

  logic [1:0]  rr_req_ready, fp_req_ready;
  logic        rr_rsp_valid, fp_rsp_valid;
  logic [31:0] rr_rsp_data, fp_rsp_data;
  logic        rr_rsp_src, fp_rsp_src;
  logic [31:0] rr_onehot, fp_onehot;
  logic        rr_right, fp_right;
  logic [31:0] rr_datain, fp_datain;
  logic [31:0] rr_dataout, fp_dataout;

  int checks;
  int failures;

  function automatic logic [31:0] shifter(input logic [31:0] oh, input logic [31:0] d);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 32; k++) if (oh[k]) r |= d << k;
    return r;
  endfunction

  assign rr_dataout = shifter(rr_onehot, rr_datain);
  assign fp_dataout = shifter(fp_onehot, fp_datain);

  shift_arb_ctrl #(.RR_EN(1), .SHAMT_W(5)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(rr_req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_shamt0(req_shamt0), .req_shamt1(req_shamt1),
    .req_data0(req_data0), .req_data1(req_data1),
    .rsp_valid(rr_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rr_rsp_data), .rsp_src(rr_rsp_src),
    .sh_onehot(rr_onehot), .sh_right(rr_right),
    .sh_datain(rr_datain), .sh_dataout(rr_dataout)
  );

  shift_arb_ctrl #(.RR_EN(0), .SHAMT_W(5)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(fp_req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_shamt0(req_shamt0), .req_shamt1(req_shamt1),
    .req_data0(req_data0), .req_data1(req_data1),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(fp_rsp_data), .rsp_src(fp_rsp_src),
    .sh_onehot(fp_onehot), .sh_right(fp_right),
    .sh_datain(fp_datain), .sh_dataout(fp_dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout got=running exp=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic scrambleFields();
    req_op0 = 2'b11; req_op1 = 2'b11;
    req_shamt0 = 5'd13; req_shamt1 = 5'd13;
    req_data0 = 32'hDEAD_BEEF; req_data1 = 32'hDEAD_BEEF;
  endtask

  // One single-requester operation; hold > 0 keeps rsp_ready low for that many RESP cycles.
  task automatic applyStimulus(input int src, input logic [1:0] op, input logic [4:0] shamt,
                               input logic [31:0] data, input logic [31:0] exp_datain,
                               input logic [31:0] exp, input bit two_pass, input int hold);
    @(negedge clk);
    rsp_ready = 1'b1;
    if (src == 0) begin
      req_op0 = op; req_shamt0 = shamt; req_data0 = data; req_valid = 2'b01;
    end else begin
      req_op1 = op; req_shamt1 = shamt; req_data1 = data; req_valid = 2'b10;
    end
    #1 checkOutput("grant", {30'd0, rr_req_ready}, (src == 0) ? 32'd1 : 32'd2);
    @(negedge clk);
    req_valid = 2'b00;
    scrambleFields();
    #1;
    checkOutput("p1_onehot", rr_onehot, 32'd1 << shamt);
    checkOutput("p1_datain", rr_datain, exp_datain);
    checkOutput("p1_valid", {31'd0, rr_rsp_valid}, 32'd0);
    if (two_pass) begin
      @(negedge clk); #1;
      checkOutput("p2_onehot", rr_onehot, 32'd1 << shamt);
      checkOutput("p2_datain", rr_datain, 32'hFFFF_FFFF);
      checkOutput("p2_valid", {31'd0, rr_rsp_valid}, 32'd0);
    end
    rsp_ready = (hold == 0);
    @(negedge clk); #1;
    checkOutput("rsp_valid", {31'd0, rr_rsp_valid}, 32'd1);
    checkOutput("rsp_data", rr_rsp_data, exp);
    checkOutput("rsp_src", {31'd0, rr_rsp_src}, src);
    checkOutput("fp_rsp_data", fp_rsp_data, exp);
    checkOutput("resp_idle_sh", rr_onehot | rr_datain, 32'd0);
    if (hold > 0) begin
      req_valid = 2'b01;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk); #1;
        checkOutput("bp_valid", {31'd0, rr_rsp_valid}, 32'd1);
        checkOutput("bp_data", rr_rsp_data, exp);
        checkOutput("bp_src", {31'd0, rr_rsp_src}, src);
        checkOutput("bp_ready", {30'd0, rr_req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    req_valid = 2'b00;
    #1 checkOutput("done_valid", {31'd0, rr_rsp_valid}, 32'd0);
  endtask

  initial begin
    int got;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    scrambleFields();
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_valid", {31'd0, rr_rsp_valid}, 32'd0);
    checkOutput("rst_data", rr_rsp_data, 32'd0);
    checkOutput("rst_src", {31'd0, rr_rsp_src}, 32'd0);
    checkOutput("rst_ready", {30'd0, rr_req_ready}, 32'd0);
    checkOutput("rst_onehot", rr_onehot, 32'd0);
    checkOutput("rst_datain", rr_datain, 32'd0);
    checkOutput("rst_right", {31'd0, rr_right}, 32'd0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    // Contention: both requesters SLL by 1 continuously.
    @(negedge clk);
    req_op0 = 2'b00; req_shamt0 = 5'd1; req_data0 = 32'h0000_0003;
    req_op1 = 2'b00; req_shamt1 = 5'd1; req_data1 = 32'h8000_0001;
    req_valid = 2'b11;
    got = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (rr_rsp_valid) begin
        checkOutput("rr_src", {31'd0, rr_rsp_src}, got % 2);
        checkOutput("rr_data", rr_rsp_data, (got % 2) ? 32'h0000_0002 : 32'h0000_0006);
        got++;
      end
      if (fp_rsp_valid) begin
        checkOutput("fp_src", {31'd0, fp_rsp_src}, 32'd0);
        checkOutput("fp_data", fp_rsp_data, 32'h0000_0006);
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    checkOutput("rr_count", got, 32'd4);

    applyStimulus(0, 2'b00, 5'd4,  32'h0000_00F1, 32'h0000_00F1, 32'h0000_0F10, 1'b0, 0);
    applyStimulus(0, 2'b01, 5'd8,  32'h8000_1200, 32'h0048_0001, 32'h0080_0012, 1'b0, 0);
    applyStimulus(0, 2'b11, 5'd8,  32'h8000_1200, 32'h0048_0001, 32'hFF80_0012, 1'b1, 0);
    applyStimulus(1, 2'b11, 5'd4,  32'h7000_0000, 32'h0000_000E, 32'h0700_0000, 1'b0, 0);
    applyStimulus(0, 2'b11, 5'd31, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 0);
    applyStimulus(1, 2'b11, 5'd0,  32'hC000_0001, 32'h8000_0003, 32'hC000_0001, 1'b1, 0);
    applyStimulus(0, 2'b10, 5'd1,  32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 0);
    applyStimulus(1, 2'b00, 5'd2,  32'h0000_1234, 32'h0000_1234, 32'h0000_48D0, 1'b0, 5);

    // Reset during PASS2 of an SRA from requester 0.
    @(negedge clk);
    req_op0 = 2'b11; req_shamt0 = 5'd8; req_data0 = 32'h8000_1200; req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1 checkOutput("abort_p2", rr_datain, 32'hFFFF_FFFF);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_valid", {31'd0, rr_rsp_valid}, 32'd0);
    checkOutput("abort_onehot", rr_onehot, 32'd0);
    checkOutput("abort_datain", rr_datain, 32'd0);
    repeat (3) @(negedge clk);
    #1 checkOutput("abort_hold", {31'd0, rr_rsp_valid}, 32'd0);
    rst_n = 1'b1;
    req_valid = 2'b11;
    #1 checkOutput("abort_ptr", {30'd0, rr_req_ready}, 32'd1);
    req_valid = 2'b00;
    applyStimulus(1, 2'b01, 5'd4, 32'h0000_00F0, 32'h0F00_0000, 32'h0000_000F, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
